div_issue_ctrl: RTL and testbench
=================================

// Module: div_issue_ctrl
// PURPOSE
//  Issue/writeback controller sitting directly upstream of the iterative divider (Division_BLOCK).
//  Accepts RV32M DIV/DIVU/REM/REMU from the execute stage and stalls the pipeline until a result exists.
//  Resolves divide-by-zero and signed overflow locally without using the divider.
//  Drives the divider's one-cycle valid pulse, waits for data_ready, then returns result + rd to writeback.
// PARAMETERS
//  XLEN     32   operand/result width
//  TIMEOUT  40   max cycles in WAIT/DRAIN before abandoning the divider; must exceed divider latency (~34)
// PORTS
//  CLK             in   1     clock, rising edge
//  rst_n           in   1     asynchronous active-low reset
//  ex_valid        in   1     M-ext div-class instruction present; held stable while stall=1
//  ex_funct3       in   3     1xx: [1:0] 00 DIV, 01 DIVU, 10 REM, 11 REMU (maps 1:1 to div_operation)
//  ex_rs1          in   XLEN  dividend
//  ex_rs2          in   XLEN  divisor
//  ex_rd           in   5     destination register
//  flush           in   1     kill in-flight instruction (branch/trap)
//  stall           out  1     hold execute stage
//  wb_valid        out  1     one-cycle result strobe
//  wb_rd           out  5     destination of wb_data
//  wb_data         out  XLEN  quotient/remainder
//  busy            out  1     state != IDLE
//  timeout_err     out  1     one-cycle pulse when TIMEOUT expires
//  div_dividend    out  XLEN  registered, stable from ISSUE until data_ready
//  div_divisor     out  XLEN  registered, as above
//  div_operation   out  2     registered ex_funct3[1:0]
//  div_data_valid  out  1     one-cycle start pulse
//  div_result      in   XLEN  divider product_o
//  div_data_ready  in   1     divider completion
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; cnt=0; internal regs 0. Reset mid-operation discards everything;
//   divider is reset by the same rst_n.
//  stall = ex_valid & ~flush & (state != RESP). Pipeline advances on the RESP edge.
//  special: rs2==0 -> DIV/DIVU: all-ones; REM/REMU: rs1.
//   DIV with rs1==2^(XLEN-1), rs2==all-ones -> 2^(XLEN-1); REM same operands -> 0.
//  FSM:
//   IDLE:  ex_valid & ~flush: latch rd, op, operands.
//           special -> result reg = special value, go RESP; else go ISSUE.
//   ISSUE: div_data_valid=1 (suppressed if flush); cnt=0.
//           flush -> IDLE (nothing issued); else -> WAIT.
//   WAIT:  cnt++. flush -> DRAIN.
//           div_data_ready -> result reg = div_result, go RESP.
//           cnt==TIMEOUT-1 -> timeout_err=1, result=all-ones, go RESP.
//   RESP:  wb_valid=1, wb_rd/wb_data from regs, stall=0, go IDLE.
//           flush in RESP suppresses wb_valid, still go IDLE.
//   DRAIN: wait div_data_ready (discard result) or TIMEOUT (timeout_err pulse), then IDLE.
//           stall=1 if ex_valid. flush ignored.
//  Priority in WAIT: flush > data_ready > timeout. data_ready outside WAIT/DRAIN is ignored.
//  Latency, ex_valid to wb_valid: special = 1 cycle (IDLE, RESP); normal = 2 + divider latency.
//  Back-to-back: instruction in the cycle after RESP is accepted from IDLE; no bubble beyond IDLE.
//  div_* operand regs are only written in IDLE on accept; they never change while busy.
//  wb_data/wb_rd hold their last value when wb_valid=0.
// TESTING
//  DIV -7/3: one div_data_valid pulse, operation=00 -> wb_data=-2 (0xFFFFFFFE), stall low only in RESP.
//  REM -149/-5 -> wb_data=-4; REMU 25/3 -> 1; DIVU 5/32 -> 0; back-to-back, no lost or duplicate wb.
//  DIVU 9/0 -> 0xFFFFFFFF; REM 9/0 -> 9; DIV 0x80000000/-1 -> 0x80000000.
//   All: no div_data_valid, wb_valid 1 cycle after accept.
//  Flush 5 cycles into WAIT of DIV 14/2 -> no wb_valid; next DIV 3/2 stalls until first ready, then wb=1.
//  Hold div_data_ready low -> timeout_err pulse at cnt=TIMEOUT-1, wb_data=0xFFFFFFFF; rst_n low mid-WAIT
//   -> all outputs 0 asynchronously, IDLE.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// Issue/writeback controller in front of the iterative RV32M divider.
// Resolves divide-by-zero and signed overflow locally and sequences the divider handshake.
module div_issue_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 40
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [4:0]      ex_rd,
    input  logic            flush,
    output logic            stall,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            busy,
    output logic            timeout_err,
    output logic [XLEN-1:0] div_dividend,
    output logic [XLEN-1:0] div_divisor,
    output logic [1:0]      div_operation,
    output logic            div_data_valid,
    input  logic [XLEN-1:0] div_result,
    input  logic            div_data_ready
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    // op[0]=0 selects the signed forms (DIV, REM), which are the only ones that can overflow
    function automatic logic is_special(input logic [1:0] op, input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b);
        logic div_zero;
        logic ovf;
        div_zero = (b == ZERO);
        ovf      = ~op[0] & (a == INT_MIN) & (b == ALL_ONES);
        return div_zero | ovf;
    endfunction

    function automatic logic [XLEN-1:0] special_value(input logic [1:0] op,
                                                      input logic [XLEN-1:0] a,
                                                      input logic [XLEN-1:0] b);
        if (b == ZERO) begin
            return op[1] ? a : ALL_ONES;
        end else begin
            return op[1] ? ZERO : INT_MIN;
        end
    endfunction

    state_t            state_r, state_n;
    logic [CW-1:0]     cnt_r, cnt_n;
    logic [4:0]        rd_r;
    logic [XLEN-1:0]   div_dividend_r, div_divisor_r;
    logic [1:0]        div_operation_r;
    logic [4:0]        wb_rd_r, wb_rd_n;
    logic [XLEN-1:0]   wb_data_r, wb_data_n;
    logic              accept_s, wb_load_s;
    logic              div_data_valid_s, wb_valid_s, timeout_s;
    logic              funct3_unused_s;

    assign funct3_unused_s = ex_funct3[2];

    // Next-state, counter and writeback-load decode
    always_comb begin
        state_n          = state_r;
        cnt_n            = cnt_r;
        accept_s         = 1'b0;
        wb_load_s        = 1'b0;
        wb_data_n        = wb_data_r;
        wb_rd_n          = rd_r;
        div_data_valid_s = 1'b0;
        wb_valid_s       = 1'b0;
        timeout_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_n = CNT_ZERO;
                if (ex_valid & ~flush) begin
                    accept_s = 1'b1;
                    if (is_special(ex_funct3[1:0], ex_rs1, ex_rs2)) begin
                        wb_load_s = 1'b1;
                        wb_data_n = special_value(ex_funct3[1:0], ex_rs1, ex_rs2);
                        wb_rd_n   = ex_rd;
                        state_n   = ST_RESP;
                    end else begin
                        state_n = ST_ISSUE;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_n = CNT_ZERO;
                if (flush) begin
                    state_n = ST_IDLE;
                end else begin
                    div_data_valid_s = 1'b1;
                    state_n          = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_n = cnt_r + CNT_ONE;
                if (flush) begin
                    state_n = ST_DRAIN;
                end else if (div_data_ready) begin
                    wb_load_s = 1'b1;
                    wb_data_n = div_result;
                    state_n   = ST_RESP;
                end else if (cnt_r == CNT_LAST) begin
                    timeout_s = 1'b1;
                    wb_load_s = 1'b1;
                    wb_data_n = ALL_ONES;
                    state_n   = ST_RESP;
                end else begin
                    state_n = ST_WAIT;
                end
            end
            ST_RESP: begin
                cnt_n      = CNT_ZERO;
                wb_valid_s = ~flush;
                state_n    = ST_IDLE;
            end
            ST_DRAIN: begin
                cnt_n = cnt_r + CNT_ONE;
                if (div_data_ready) begin
                    state_n = ST_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    timeout_s = 1'b1;
                    state_n   = ST_IDLE;
                end else begin
                    state_n = ST_DRAIN;
                end
            end
            default: begin
                cnt_n   = CNT_ZERO;
                state_n = ST_IDLE;
            end
        endcase
    end

    // FSM state and WAIT/DRAIN cycle counter
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    // Operands and destination are captured only on accept, so the divider sees stable inputs
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rd_r            <= 5'd0;
            div_dividend_r  <= ZERO;
            div_divisor_r   <= ZERO;
            div_operation_r <= 2'b00;
        end else if (accept_s) begin
            rd_r            <= ex_rd;
            div_dividend_r  <= ex_rs1;
            div_divisor_r   <= ex_rs2;
            div_operation_r <= ex_funct3[1:0];
        end
    end

    // Writeback payload, loaded on entry to RESP and held otherwise
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            wb_rd_r   <= 5'd0;
            wb_data_r <= ZERO;
        end else if (wb_load_s) begin
            wb_rd_r   <= wb_rd_n;
            wb_data_r <= wb_data_n;
        end
    end

    // DRAIN keeps the pipeline held even under flush, the divider is still busy
    assign stall          = ex_valid & ((state_r == ST_DRAIN) |
                                        (~flush & (state_r != ST_RESP)));
    assign wb_valid       = wb_valid_s;
    assign wb_rd          = wb_rd_r;
    assign wb_data        = wb_data_r;
    assign busy           = (state_r != ST_IDLE);
    assign timeout_err    = timeout_s;
    assign div_dividend   = div_dividend_r;
    assign div_divisor    = div_divisor_r;
    assign div_operation  = div_operation_r;
    assign div_data_valid = div_data_valid_s;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: table of div/rem vectors with a writeback scoreboard,
// a behavioural stand-in divider, and hand sequences for flush, timeout and reset.
module tb_div_issue_ctrl;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 40;
    localparam int LAT     = 34;

    logic            CLK = 1'b0;
    logic            rst_n;
    logic            ex_valid;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_rs1, ex_rs2;
    logic [4:0]      ex_rd;
    logic            flush;
    logic            stall, wb_valid, busy, timeout_err, div_data_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data, div_dividend, div_divisor, div_result;
    logic [1:0]      div_operation;
    logic            div_data_ready;

    div_issue_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .rst_n(rst_n), .ex_valid(ex_valid), .ex_funct3(ex_funct3),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .flush(flush),
        .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .busy(busy), .timeout_err(timeout_err), .div_dividend(div_dividend),
        .div_divisor(div_divisor), .div_operation(div_operation),
        .div_data_valid(div_data_valid), .div_result(div_result),
        .div_data_ready(div_data_ready)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic [31:0] exp;
        bit          spec;
    } vec_t;

    exp_t        exp_q[$];
    vec_t        tbl[13];
    int          vectors = 0;
    int          miscompares = 0;
    int          n_issue = 0;
    logic [1:0]  cur_op;
    logic [31:0] cur_rs1, cur_rs2;
    bit          hold_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            2'b00:   ref_div = $signed(a) / $signed(b);
            2'b01:   ref_div = a / b;
            2'b10:   ref_div = $signed(a) % $signed(b);
            default: ref_div = a % b;
        endcase
    endfunction

    // Stand-in iterative divider: fixed latency, one-cycle ready pulse
    bit          m_busy;
    int          m_cnt;
    logic [31:0] m_res;
    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_cnt <= 0; m_res <= 32'd0;
            div_data_ready <= 1'b0; div_result <= 32'd0;
        end else begin
            div_data_ready <= 1'b0;
            if (div_data_valid && !hold_ready) begin
                m_busy <= 1'b1;
                m_cnt  <= LAT;
                m_res  <= ref_div(div_operation, div_dividend, div_divisor);
            end else if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy         <= 1'b0;
                    div_data_ready <= 1'b1;
                    div_result     <= m_res;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    // Monitor: issue operands and scoreboard of writebacks
    always @(negedge CLK) begin
        if (rst_n) begin
            if (div_data_valid === 1'b1) begin
                n_issue++;
                check("issue_op", div_operation, cur_op);
                check("issue_rs1", div_dividend, cur_rs1);
                check("issue_rs2", div_divisor, cur_rs2);
            end
            if (wb_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL wb_unexpected: got rd=%0d data=0x%0h, want no writeback", wb_rd, wb_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("wb_rd", wb_rd, e.rd);
                    check("wb_data", wb_data, e.data);
                end
            end
        end
    end

    task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        cur_op    = f3[1:0];
        cur_rs1   = a;
        cur_rs2   = b;
        ex_funct3 = f3;
        ex_rs1    = a;
        ex_rs2    = b;
        ex_rd     = rd;
        ex_valid  = 1'b1;
    endtask

    task automatic wait_issue(input string nm);
        bit ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (div_data_valid === 1'b1) begin ok = 1'b1; break; end
        end
        check(nm, ok, 64'd1);
    endtask

    task automatic run_instr(input vec_t v, input string nm);
        int lat = 0;
        int iss0;
        bit bad = 1'b0;
        bit got = 1'b0;
        iss0 = n_issue;
        exp_q.push_back('{v.rd, v.exp});
        drive(v.f3, v.rs1, v.rs2, v.rd);
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            if (stall !== !wb_valid) bad = 1'b1;
            if (wb_valid === 1'b1) begin got = 1'b1; break; end
            lat++;
        end
        check({nm, "_wb_seen"}, got, 64'd1);
        check({nm, "_latency"}, lat, v.spec ? 64'd1 : 64'(LAT + 3));
        check({nm, "_issues"}, n_issue - iss0, v.spec ? 64'd0 : 64'd1);
        check({nm, "_stall"}, bad, 64'd0);
        @(posedge CLK); #1;
        ex_valid = 1'b0;
    endtask

    initial begin
        vec_t rec;
        bit   bad;
        bit   seen;
        int   n;
        int   iss0;

        tbl[0]  = '{3'b100, 32'hFFFF_FFF9, 32'd3,        5'd1,  32'hFFFF_FFFE, 1'b0};
        tbl[1]  = '{3'b110, 32'hFFFF_FF6B, 32'hFFFF_FFFB, 5'd2,  32'hFFFF_FFFC, 1'b0};
        tbl[2]  = '{3'b111, 32'd25,        32'd3,        5'd3,  32'd1,         1'b0};
        tbl[3]  = '{3'b101, 32'd5,         32'd32,       5'd4,  32'd0,         1'b0};
        tbl[4]  = '{3'b101, 32'd9,         32'd0,        5'd5,  32'hFFFF_FFFF, 1'b1};
        tbl[5]  = '{3'b110, 32'd9,         32'd0,        5'd6,  32'd9,         1'b1};
        tbl[6]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  32'h8000_0000, 1'b1};
        tbl[7]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'd0,         1'b1};
        tbl[8]  = '{3'b100, 32'd9,         32'd0,        5'd9,  32'hFFFF_FFFF, 1'b1};
        tbl[9]  = '{3'b111, 32'd9,         32'd0,        5'd10, 32'd9,         1'b1};
        tbl[10] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0,         1'b0};
        tbl[11] = '{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1'b0};
        tbl[12] = '{3'b100, 32'd100,       32'd7,        5'd31, 32'd14,        1'b0};

        rst_n = 1'b0; ex_valid = 1'b0; ex_funct3 = 3'b000; ex_rs1 = 32'd0;
        ex_rs2 = 32'd0; ex_rd = 5'd0; flush = 1'b0;
        cur_op = 2'b00; cur_rs1 = 32'd0; cur_rs2 = 32'd0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_ctrl", {stall, wb_valid, busy, timeout_err, div_data_valid, wb_rd, div_operation}, 64'd0);
        check("reset_data", {wb_data, div_dividend}, 64'd0);
        check("reset_divisor", div_divisor, 64'd0);
        @(posedge CLK); #1;
        rst_n = 1'b1;
        @(posedge CLK); #1;

        // Back-to-back table
        for (int i = 0; i < 13; i++) begin
            run_instr(tbl[i], $sformatf("vec%0d", i));
        end
        check("queue_empty_table", exp_q.size(), 64'd0);

        // Flush in IDLE: not accepted
        drive(3'b100, 32'd7, 32'd1, 5'd13);
        flush = 1'b1;
        @(negedge CLK);
        check("idle_flush_stall", stall, 64'd0);
        @(posedge CLK); #1;
        ex_valid = 1'b0; flush = 1'b0;
        @(negedge CLK);
        check("idle_flush_busy", busy, 64'd0);
        @(posedge CLK); #1;

        // Flush in RESP suppresses the writeback
        drive(3'b101, 32'd9, 32'd0, 5'd14);
        @(posedge CLK); #1;
        flush = 1'b1; ex_valid = 1'b0;
        @(negedge CLK);
        check("resp_flush_wb", {wb_valid, busy}, 64'd1);
        @(posedge CLK); #1;
        flush = 1'b0;
        @(negedge CLK);
        check("resp_flush_idle", busy, 64'd0);
        @(posedge CLK); #1;

        // Flush 5 cycles into WAIT, then the next divide waits behind DRAIN
        iss0 = n_issue;
        drive(3'b100, 32'd14, 32'd2, 5'd3);
        wait_issue("flush_first_issue");
        repeat (6) @(posedge CLK);
        #1;
        flush = 1'b1; ex_valid = 1'b0;
        @(posedge CLK); #1;
        flush = 1'b0;
        exp_q.push_back('{5'd4, 32'd1});
        drive(3'b100, 32'd3, 32'd2, 5'd4);
        bad = 1'b0; seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge CLK);
            if (stall !== 1'b1 || wb_valid !== 1'b0 || busy !== 1'b1) bad = 1'b1;
            if (div_data_ready === 1'b1) begin seen = 1'b1; break; end
        end
        check("drain_ready_seen", seen, 64'd1);
        check("drain_stall", bad, 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if (wb_valid === 1'b1) begin seen = 1'b1; break; end
        end
        check("after_drain_wb", seen, 64'd1);
        check("flush_issues", n_issue - iss0, 64'd2);
        @(posedge CLK); #1;
        ex_valid = 1'b0;

        // Divider never answers: timeout after TIMEOUT cycles in WAIT
        hold_ready = 1'b1;
        exp_q.push_back('{5'd9, 32'hFFFF_FFFF});
        drive(3'b100, 32'd100, 32'd7, 5'd9);
        wait_issue("to_issue");
        n = 0; seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            n++;
            if (timeout_err === 1'b1) begin seen = 1'b1; break; end
        end
        check("to_seen", seen, 64'd1);
        check("to_cycle", n, 64'(TIMEOUT));
        @(negedge CLK);
        check("to_pulse_resp", {timeout_err, wb_valid}, 64'd1);
        @(posedge CLK); #1;
        ex_valid = 1'b0;
        @(posedge CLK); #1;

        // Asynchronous reset in the middle of WAIT
        drive(3'b100, 32'd14, 32'd2, 5'd6);
        wait_issue("rst_issue");
        repeat (3) @(posedge CLK);
        #3;
        rst_n = 1'b0; ex_valid = 1'b0;
        #1;
        check("arst_ctrl", {stall, wb_valid, busy, timeout_err, div_data_valid, wb_rd, div_operation}, 64'd0);
        check("arst_data", {wb_data, div_dividend}, 64'd0);
        check("arst_divisor", div_divisor, 64'd0);
        @(negedge CLK);
        rst_n = 1'b1; hold_ready = 1'b0;
        @(posedge CLK); #1;
        rec = '{3'b101, 32'd5, 32'd32, 5'd17, 32'd0, 1'b0};
        run_instr(rec, "recover");

        repeat (3) @(negedge CLK);
        check("queue_empty_end", exp_q.size(), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
